// File: rtl/ysyx_fetch_decode.sv
// rtl/ysyx_fetch_decode.sv - multi-cycle fetch/decode front end (addi, ebreak) for the ysyx core
//
// Owns the PC, fetches one 32-bit word at a time over a valid/ready request
// port plus a valid-only response port, decodes it and presents it to the
// execute stage over a valid/ready handshake. Fetch stops for good after an
// ebreak has been handed over, until the next reset.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   imem_req_valid/ready     fetch request handshake
//   imem_req_addr            fetch address, always the current pc
//   imem_rsp_valid/data      instruction word return (sampled only while waiting)
//   out_valid/out_ready      decoded-instruction handshake towards execute
//   rs1, rd, imm             register indices and sign-extended I-type immediate
//   rf_wr_en                 one-cycle write strobe, on handover of an addi
//   is_ebreak                presented instruction is ebreak
//   illegal                  instruction is neither addi nor ebreak
//   pc                       address of the current instruction
//   halted                   fetch stopped after ebreak
module ysyx_fetch_decode #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [4:0]  rs1,
   output logic [4:0]  rd,
   output logic [31:0] imm,
   output logic        rf_wr_en,
   output logic        is_ebreak,
   output logic        illegal,
   output logic [31:0] pc,
   output logic        halted
);

   localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;
   localparam logic [6:0]  OP_IMM      = 7'b0010011;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      WAIT  = 3'd2,
      ISSUE = 3'd3,
      HALT  = 3'd4
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic        rst_hold;
   logic [31:0] inst;
   logic        dec_addi;
   logic        dec_ebreak;
   logic        fire;

   // Reset release is registered once so IDLE lasts one full edge after
   // deassertion; the first request appears on the second rising edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rst_hold <= 1'b1;
      end else begin
         rst_hold <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc   <= RESET_PC;
         inst <= 32'd0;
      end else begin
         // Responses outside WAIT (late or spurious) never reach the register.
         if (state == WAIT && imem_rsp_valid) begin
            inst <= imem_rsp_data;
         end
         // ebreak leaves pc pointing at itself.
         if (fire && !dec_ebreak) begin
            pc <= pc + 32'd4;
         end
      end
   end

   always_comb begin
      state_nxt      = state;
      imem_req_valid = 1'b0;
      out_valid      = 1'b0;
      fire           = 1'b0;
      halted         = 1'b0;
      case (state)
         IDLE: begin
            if (!rst_hold) begin
               state_nxt = REQ;
            end
         end
         REQ: begin
            imem_req_valid = 1'b1;
            if (imem_req_ready) begin
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (imem_rsp_valid) begin
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            out_valid = 1'b1;
            fire      = out_ready;
            if (out_ready) begin
               state_nxt = dec_ebreak ? HALT : REQ;
            end
         end
         HALT: begin
            halted = 1'b1;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign dec_addi   = (inst[6:0] == OP_IMM) && (inst[14:12] == 3'b000);
   assign dec_ebreak = (inst == EBREAK_WORD);

   assign imem_req_addr = pc;
   assign rs1           = inst[19:15];
   assign rd            = inst[11:7];
   assign imm           = {{20{inst[31]}}, inst[31:20]};
   assign illegal       = !dec_addi && !dec_ebreak;
   // Strobe only on the handover cycle so stalls never repeat the write.
   assign rf_wr_en      = fire && dec_addi;
   assign is_ebreak     = out_valid && dec_ebreak;

endmodule

// File: tb/tb_ysyx_fetch_decode.sv
// tb/tb_ysyx_fetch_decode.sv - scoreboard bench for ysyx_fetch_decode with randomized memory and execute stalls
module tb_ysyx_fetch_decode;

   localparam logic [31:0] RESET_PC = 32'h8000_0000;
   localparam logic [31:0] EBREAK   = 32'h0010_0073;
   localparam logic [31:0] ADDI5    = 32'h0050_0093;
   localparam logic [31:0] ADDI_NEG = 32'hFFF0_8113;
   localparam logic [31:0] ADD_R    = 32'h0000_0033;
   localparam logic [31:0] STALE    = 32'h00A3_8393;

   logic        clk;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  rs1;
   logic [4:0]  rd;
   logic [31:0] imm;
   logic        rf_wr_en;
   logic        is_ebreak;
   logic        illegal;
   logic [31:0] pc;
   logic        halted;

   ysyx_fetch_decode #(.RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .rs1(rs1), .rd(rd), .imm(imm),
      .rf_wr_en(rf_wr_en), .is_ebreak(is_ebreak), .illegal(illegal),
      .pc(pc), .halted(halted)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] inst;
   } exp_t;

   exp_t        exp_q[$];
   int          acc_q[$];
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          fires = 0;
   int          wr_cnt = 0;
   int          exp_wr_cnt = 0;
   int          eb_cnt = 0;
   logic [31:0] pc_exp;

   // stimulus controls shared between the main sequence and the memory model
   logic        mem_en = 0;
   logic        mon_en = 0;
   logic        mode_fixed = 1;
   logic [31:0] fixed_inst = ADDI5;
   logic        rand_stall = 0;
   logic        spur_en = 0;
   logic        hold = 0;
   logic        pending = 0;
   logic [31:0] pend_addr;
   logic [31:0] pend_inst;
   int          delay = 0;
   logic        prev_stalled = 0;
   logic [31:0] prev_addr;

   initial clk = 0;
   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] gen_inst();
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 4))
         0, 1: begin
            w[6:0]   = 7'b0010011;
            w[14:12] = 3'd0;
         end
         2: begin
            w[6:0]   = 7'b0010011;
            w[14:12] = 3'($urandom_range(1, 7));
         end
         3: w = EBREAK ^ (32'd1 << $urandom_range(0, 31));
         default: ;
      endcase
      if (w == EBREAK) w = w ^ 32'h8000_0000;
      return w;
   endfunction

   // memory model and execute-side ready driver; acts on falling edges
   initial forever begin
      @(negedge clk);
      if (mem_en) begin
         imem_req_ready = rand_stall ? ($urandom_range(0, 2) != 0) : 1'b1;
         out_ready      = rand_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (pending) begin
            prev_stalled = 0;
            if (delay == 0 && !hold) begin
               imem_rsp_valid = 1'b1;
               imem_rsp_data  = pend_inst;
               exp_q.push_back('{addr: pend_addr, inst: pend_inst});
               pending = 0;
            end else begin
               if (!hold) delay--;
               imem_rsp_valid = 1'b0;
               imem_rsp_data  = $urandom;
            end
         end else begin
            imem_rsp_valid = spur_en ? ($urandom_range(0, 1) == 1) : 1'b0;
            imem_rsp_data  = $urandom;
            if (imem_req_valid) begin
               if (prev_stalled) chk("req_addr_stable", imem_req_addr, prev_addr);
               prev_stalled = !imem_req_ready;
               prev_addr    = imem_req_addr;
               if (imem_req_ready) begin
                  pending   = 1;
                  pend_addr = imem_req_addr;
                  pend_inst = mode_fixed ? fixed_inst : gen_inst();
                  delay     = rand_stall ? $urandom_range(0, 3) : 0;
                  acc_q.push_back(cyc);
               end
            end else begin
               prev_stalled = 0;
            end
         end
      end
   end

   // scoreboard monitor: compares presented instructions against the decode rules
   initial forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
         if (rf_wr_en) wr_cnt++;
         if (is_ebreak) eb_cnt++;
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
               exp_t        e;
               logic [31:0] w;
               logic        m_addi;
               logic        m_eb;
               e      = exp_q[0];
               w      = e.inst;
               m_addi = (w % 128 == 32'h13) && ((w / 4096) % 8 == 0);
               m_eb   = (w == EBREAK);
               chk("rs1", 32'(rs1), (w / 32768) % 32);
               chk("rd", 32'(rd), (w / 128) % 32);
               chk("imm", imm, 32'($signed(w) >>> 20));
               chk("illegal", 32'(illegal), 32'(!m_addi && !m_eb));
               chk("is_ebreak", 32'(is_ebreak), 32'(m_eb));
               chk("pc", pc, pc_exp);
               chk("fetch_addr", e.addr, pc_exp);
               if (out_ready) begin
                  chk("rf_wr_en_fire", 32'(rf_wr_en), 32'(m_addi));
                  if (m_addi) exp_wr_cnt++;
                  if (!m_eb) pc_exp = pc_exp + 32'd4;
                  void'(exp_q.pop_front());
                  fires++;
               end else begin
                  chk("rf_wr_en_stall", 32'(rf_wr_en), 32'd0);
               end
            end
         end else begin
            chk("rf_wr_en_idle", 32'(rf_wr_en), 32'd0);
            chk("is_ebreak_idle", 32'(is_ebreak), 32'd0);
         end
      end
   end

   task automatic wait_fires(input int target, input string name);
      int n;
      n = 0;
      while (fires < target && n < 3000) begin
         @(posedge clk);
         n++;
      end
      chk(name, 32'(fires >= target), 32'd1);
   endtask

   initial begin : main_seq
      int n;
      rst = 1;
      imem_req_ready = 1;
      imem_rsp_valid = 0;
      imem_rsp_data  = 0;
      out_ready      = 0;

      // reset values and start-up timing
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_rf_wr_en", 32'(rf_wr_en), 32'd0);
      chk("rst_is_ebreak", 32'(is_ebreak), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_pc", pc, RESET_PC);
      chk("rst_imm", imm, 32'd0);
      rst = 0;
      @(posedge clk); #1;
      chk("req_edge1", 32'(imem_req_valid), 32'd0);
      @(posedge clk); #1;
      chk("req_edge2", 32'(imem_req_valid), 32'd1);
      chk("req_addr_start", imem_req_addr, RESET_PC);

      // zero-wait addi stream: 3 cycles per instruction
      pc_exp = RESET_PC;
      acc_q.delete();
      mon_en = 1;
      mem_en = 1;
      wait_fires(4, "addi_stream_done");
      for (int i = 0; i < 3; i++) chk("throughput", 32'(acc_q[i + 1] - acc_q[i]), 32'd3);
      chk("addi_wr_pulses", 32'(wr_cnt), 32'd4);

      // negative immediate under random stalls
      fixed_inst = ADDI_NEG;
      rand_stall = 1;
      wait_fires(fires + 6, "neg_imm_done");

      // random mix with spurious responses
      mode_fixed = 0;
      spur_en    = 1;
      wait_fires(fires + 60, "random_done");

      // illegal R-type with spurious responses
      mode_fixed = 1;
      fixed_inst = ADD_R;
      wait_fires(fires + 4, "illegal_done");
      chk("wr_pulse_total", 32'(wr_cnt), 32'(exp_wr_cnt));

      // reset while waiting for a response; stale response lands in IDLE
      fixed_inst = ADDI5;
      rand_stall = 0;
      spur_en    = 0;
      hold       = 1;
      n = 0;
      while (n < 300) begin
         @(posedge clk); #1;
         if (pending && !imem_req_valid && !out_valid) break;
         n++;
      end
      chk("reach_wait", 32'(n < 300), 32'd1);
      mon_en = 0;
      mem_en = 0;
      rst    = 1;
      #1;
      chk("midrst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("midrst_pc", pc, RESET_PC);
      pending = 0;
      hold    = 0;
      exp_q.delete();
      imem_rsp_valid = 1;
      imem_rsp_data  = STALE;
      imem_req_ready = 0;
      out_ready      = 1;
      repeat (2) @(negedge clk);
      rst = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("restart_req_valid", 32'(imem_req_valid), 32'd1);
      chk("restart_addr", imem_req_addr, RESET_PC);
      chk("stale_rd", 32'(rd), 32'd0);
      chk("stale_imm", imm, 32'd0);
      @(negedge clk);
      imem_rsp_valid = 0;
      pc_exp       = RESET_PC;
      prev_stalled = 0;
      mon_en = 1;
      mem_en = 1;
      wait_fires(fires + 3, "restart_done");

      // ebreak halts fetch with pc frozen
      fixed_inst = EBREAK;
      eb_cnt = 0;
      n = 0;
      while (!halted && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      chk("halt_reached", 32'(halted), 32'd1);
      @(negedge clk); #3;
      chk("ebreak_cycles", 32'(eb_cnt), 32'd1);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         chk("halt_no_req", 32'(imem_req_valid), 32'd0);
         chk("halt_flag", 32'(halted), 32'd1);
         chk("halt_pc", pc, pc_exp);
      end
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
